// File: rtl/hull_fault_filter.sv
// Hull motor-driver fault conditioning: 2-flop sync, debounce, latch-until-ack, saturating counter.
// Optional registered interrupt pulse on FAULT entry when HULL_FAULT_IRQ_EN is defined.
module hull_fault_filter #(
  parameter int FILTER_CYCLES    = 50,
  parameter int CNT_W            = 8,
  parameter bit FAULT_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fault_pin,
  input  logic             clear,
  output logic             fault_out,
  output logic             fault_live,
  output logic [CNT_W-1:0] fault_count,
  output logic             fault_irq
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FAULT = 2'd1,
    HELD  = 2'd2
  } state_t;

  // Non-fault pin level; the synchroniser starts here so reset never shows a fault.
  localparam logic       IDLE_LEVEL = FAULT_ACTIVE_LOW;
  localparam logic [15:0] FILT_LAST = 16'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       sync_reg;
  logic [15:0]      filt_cnt_reg;
  logic             live_reg;
  logic             live_d_reg;
  state_t           state_reg, state_next;
  logic             out_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             f_norm;
  logic             live_rise;
  logic             live_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= {2{IDLE_LEVEL}};
    end else begin
      sync_reg <= {sync_reg[0], fault_pin};
    end
  end

  assign f_norm = sync_reg[1] ^ FAULT_ACTIVE_LOW;

  // Level only changes after FILTER_CYCLES consecutive samples that disagree with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_cnt_reg <= 16'd0;
      live_reg     <= 1'b0;
    end else if (f_norm == live_reg) begin
      filt_cnt_reg <= 16'd0;
    end else if (filt_cnt_reg == FILT_LAST) begin
      live_reg     <= f_norm;
      filt_cnt_reg <= 16'd0;
    end else begin
      filt_cnt_reg <= filt_cnt_reg + 16'd1;
    end
  end

  assign live_rise = live_reg & ~live_d_reg;
  assign live_fall = ~live_reg & live_d_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (live_rise) state_next = FAULT;
      FAULT:   if (live_fall) state_next = HELD;
      HELD: begin
        // A fresh fault outranks a simultaneous acknowledge.
        if (live_rise)  state_next = FAULT;
        else if (clear) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = live_rise ? CNT_ONE : '0;
    end else if (live_rise && (count_reg != CNT_MAX)) begin
      count_next = count_reg + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      out_reg    <= 1'b0;
      live_d_reg <= 1'b0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      out_reg    <= (state_next != IDLE);
      live_d_reg <= live_reg;
      count_reg  <= count_next;
    end
  end

`ifdef HULL_FAULT_IRQ_EN
  logic irq_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= (state_reg != FAULT) && (state_next == FAULT);
    end
  end

  assign fault_irq = irq_reg;
`else
  assign fault_irq = 1'b0;
`endif

  assign fault_out   = out_reg;
  assign fault_live  = live_reg;
  assign fault_count = count_reg;

endmodule

// File: tb/tb_hull_fault_filter.sv
// Scoreboard bench for hull_fault_filter (FILTER_CYCLES=4, CNT_W=2, active-low pin).
// Stimulus queues expected outputs tagged with a cycle; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_hull_fault_filter;

`ifdef HULL_FAULT_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       fault_pin;
  logic       clear;
  logic       fault_out;
  logic       fault_live;
  logic [1:0] fault_count;
  logic       fault_irq;

  typedef struct {
    string      name;
    int         cyc;
    logic       live;
    logic       out;
    logic [1:0] cnt;
    logic       irq;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  hull_fault_filter #(
    .FILTER_CYCLES   (4),
    .CNT_W           (2),
    .FAULT_ACTIVE_LOW(1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fault_pin  (fault_pin),
    .clear      (clear),
    .fault_out  (fault_out),
    .fault_live (fault_live),
    .fault_count(fault_count),
    .fault_irq  (fault_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      total++;
      if ({fault_live, fault_out, fault_count, fault_irq} !==
          {mon_e.live, mon_e.out, mon_e.cnt, mon_e.irq}) begin
        bad++;
        $display("FAIL %s cyc=%0d: got live=%b out=%b cnt=%0d irq=%b, want live=%b out=%b cnt=%0d irq=%b",
                 mon_e.name, cyc, fault_live, fault_out, fault_count, fault_irq,
                 mon_e.live, mon_e.out, mon_e.cnt, mon_e.irq);
      end else begin
        $display("ok   %s cyc=%0d live=%b out=%b cnt=%0d irq=%b",
                 mon_e.name, cyc, fault_live, fault_out, fault_count, fault_irq);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input string name, input logic live, input logic out,
                          input logic [1:0] cnt, input logic irq);
    exp_t e;
    e.name = name;
    e.cyc  = cyc;
    e.live = live;
    e.out  = out;
    e.cnt  = cnt;
    e.irq  = irq;
    sb_q.push_back(e);
  endtask

  // Qualify a fault from IDLE/HELD, then release it back to HELD.
  task automatic fault_cycle(input logic [1:0] exp_cnt);
    fault_pin = 1'b0;
    repeat (6) tick();
    tick();
    push_exp("sat_rise", 1'b1, 1'b1, exp_cnt, IRQ_EXP);
    fault_pin = 1'b1;
    repeat (7) tick();
    push_exp("sat_held", 1'b0, 1'b1, exp_cnt, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; fault_pin = 1'b1; clear = 1'b0;
    tick(); tick();
    push_exp("reset", 1'b0, 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      push_exp("idle", 1'b0, 1'b0, 2'd0, 1'b0);
    end

    // First qualified fault: live on edge 6, out/count/irq on edge 7.
    fault_pin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      push_exp("deb", 1'b0, 1'b0, 2'd0, 1'b0);
    end
    tick(); push_exp("live_rise", 1'b1, 1'b0, 2'd0, 1'b0);
    tick(); push_exp("out_rise", 1'b1, 1'b1, 2'd1, IRQ_EXP);
    tick(); push_exp("fault_hold", 1'b1, 1'b1, 2'd1, 1'b0);

    // clear while fault present: latch stays, counter zeroes.
    clear = 1'b1; tick(); clear = 1'b0;
    push_exp("clr_in_fault", 1'b1, 1'b1, 2'd0, 1'b0);

    fault_pin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      push_exp("rel_deb", 1'b1, 1'b1, 2'd0, 1'b0);
    end
    tick(); push_exp("live_fall", 1'b0, 1'b1, 2'd0, 1'b0);
    tick(); push_exp("held", 1'b0, 1'b1, 2'd0, 1'b0);
    clear = 1'b1; tick(); clear = 1'b0;
    push_exp("clr_held", 1'b0, 1'b0, 2'd0, 1'b0);

    // 3-sample glitch must be rejected.
    fault_pin = 1'b0;
    repeat (3) tick();
    push_exp("glitch", 1'b0, 1'b0, 2'd0, 1'b0);
    fault_pin = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      push_exp("glitch_after", 1'b0, 1'b0, 2'd0, 1'b0);
    end

    // Fault, release to HELD, then a new rise coinciding with clear.
    fault_pin = 1'b0;
    repeat (7) tick();
    push_exp("fault2", 1'b1, 1'b1, 2'd1, IRQ_EXP);
    fault_pin = 1'b1;
    repeat (7) tick();
    push_exp("held2", 1'b0, 1'b1, 2'd1, 1'b0);
    fault_pin = 1'b0;
    repeat (6) tick();
    push_exp("rise_held", 1'b1, 1'b1, 2'd1, 1'b0);
    clear = 1'b1; tick(); clear = 1'b0;
    push_exp("rise_clr", 1'b1, 1'b1, 2'd1, IRQ_EXP);
    fault_pin = 1'b1;
    repeat (7) tick();
    push_exp("held3", 1'b0, 1'b1, 2'd1, 1'b0);
    clear = 1'b1; tick(); clear = 1'b0;
    push_exp("clr3", 1'b0, 1'b0, 2'd0, 1'b0);

    // Saturation at 2^CNT_W-1 with no clear.
    fault_cycle(2'd1);
    fault_cycle(2'd2);
    fault_cycle(2'd3);
    fault_cycle(2'd3);
    fault_cycle(2'd3);

    // Reset mid-debounce, then the still-faulted pin requalifies from scratch.
    fault_pin = 1'b0;
    repeat (3) tick();
    reset = 1'b1; tick();
    push_exp("rst_mid", 1'b0, 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      push_exp("requal", 1'b0, 1'b0, 2'd0, 1'b0);
    end
    tick(); push_exp("requal_live", 1'b1, 1'b0, 2'd0, 1'b0);
    tick(); push_exp("requal_out", 1'b1, 1'b1, 2'd1, IRQ_EXP);

    tick(); tick();
    if (sb_q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
      bad += sb_q.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hull_fault_filter.md
Name: hull_fault_filter

Overview:
- Conditioning stage between the raw hull motor-driver fault pin and the single-bit hull-fault PIO input port.
- Synchronises and debounces the pin, and latches a fault until software acknowledges it.
- Counts fault occurrences.
- fault_out drives the PIO in_port directly; the PIO samples it on its own clock.

Parameters:
- FILTER_CYCLES, 50, consecutive stable synchronised samples required to change the filtered level (1 us at 50 MHz); legal range 1..65535.
- CNT_W, 8, width of the saturating fault-event counter.
- FAULT_ACTIVE_LOW, 1, 1 = pin low means fault; 0 = pin high means fault.

Ports:
- clk  input  1  system clock, same domain as the PIO
- reset  input  1  synchronous, active-high reset
- fault_pin  input  1  raw asynchronous driver fault pin
- clear  input  1  one-cycle acknowledge pulse from the control register
- fault_out  output  1  latched fault, to the PIO in_port
- fault_live  output  1  debounced present fault level
- fault_count  output  CNT_W  saturating count of fault rising edges
- fault_irq  output  1  optional; see Optional Feature

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset); it takes priority over all other inputs.
- Reset values:
  - sync flops are loaded with the NON-fault pin level (no false fault out of reset);
  - filter counter = 0; fault_live = 0; state = IDLE; fault_out = 0; fault_count = 0; fault_irq = 0.
- Synchroniser: 2 flops on fault_pin. The polarity is normalised after the 2nd flop: f = sync2 XOR FAULT_ACTIVE_LOW, so f = 1 means fault.
- Debounce:
  - 16-bit counter.
  - If f == fault_live: counter <= 0.
  - Else if counter == FILTER_CYCLES-1: fault_live <= f and counter <= 0.
  - Else: counter <= counter+1.
  - A glitch shorter than FILTER_CYCLES samples never reaches fault_live.
- Latency: a stable pin transition reaches fault_live exactly 2 + FILTER_CYCLES clk edges after the first edge that samples it.
- Latch FSM, state encoded as 2 bits:
  - IDLE: fault_live rising -> FAULT.
  - FAULT: fault_live falling -> HELD. clear is ignored while in FAULT.
  - HELD: clear -> IDLE. A new fault_live rise -> FAULT; if clear arrives in the same cycle as the rise, the rise wins and the next state is FAULT.
- fault_out = (state != IDLE), registered alongside the state. It rises 1 cycle after fault_live rises.
- A fault cannot be cleared while still present. Software must clear after the pin releases.
- Counter:
  - fault_count increments on every fault_live 0->1 transition.
  - It saturates at 2^CNT_W-1 and never wraps.
  - clear sets it to 0 in any state.
  - clear coincident with a rising edge gives fault_count = 1.
- clear held high for several cycles acts as repeated clears. There is no edge detection on clear.
- Reset mid-debounce or mid-fault: every element returns to its reset values at the next edge. A pin still faulted after reset is re-qualified through the full 2 + FILTER_CYCLES latency.

Optional Feature:
- Macro: HULL_FAULT_IRQ_EN.
- Defined:
  - fault_irq is a registered 1-cycle pulse, in the same cycle fault_out first rises from IDLE.
  - FAULT re-entry from HELD also pulses.
  - Reset value 0.
- Undefined:
  - the fault_irq port still exists and is tied to 0;
  - no pulse logic is synthesised;
  - all other behaviour is identical.

Test Plan:
- Reset with pin at the idle level (1, FAULT_ACTIVE_LOW=1), FILTER_CYCLES=4 -> fault_out=0, fault_live=0, fault_count=0 for 20 cycles.
- Pin driven 0 and held -> fault_live=1 exactly 6 edges later and fault_out=1 one edge after that; fault_count=1; fault_irq pulses for 1 cycle (with HULL_FAULT_IRQ_EN).
- Pin 0 for 3 cycles, then back to 1 -> fault_live, fault_out and fault_count remain 0.
- Fault present, clear pulsed -> fault_out stays 1. Pin released and held 1 -> fault_live=0 after 6 edges, fault_out still 1. clear pulsed -> fault_out=0 and fault_count=0 on the next edge.
- In HELD, a new qualified fault and clear land on the same edge -> state FAULT, fault_out=1, fault_count=1.
- CNT_W=2, 5 qualified fault pulses with no clear -> fault_count reads 1, 2, 3, 3, 3. reset asserted mid-debounce -> all outputs 0 on the next edge.
